// File: rtl/radar_pkg.sv
// Shared definitions for the radar frame scheduler.
//   sched_state_e : scheduler FSM states
//   IDX_W_DEF     : default row/column index width
//   CH_W_DEF      : default channel number width
//   BEAT_W        : width able to hold chans * ceil(rows/2) * cols at default widths
package radar_pkg;

    localparam int unsigned IDX_W_DEF = 11;
    localparam int unsigned CH_W_DEF  = 4;
    localparam int unsigned BEAT_W    = 2 * IDX_W_DEF + CH_W_DEF;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } sched_state_e;

endpackage

// File: rtl/radar_idx_counter.sv
// Loadable up-counter with a configurable step and a "last value" flag.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : clear the count to zero (has priority over enable)
//   enable       : advance by STEP, or wrap to zero when already on the last value
//   limit        : number of positions; the last value is the one where value+STEP >= limit
//   value        : current count
//   wrap         : current value is the last one before wrapping
module radar_idx_counter #(
    parameter int unsigned W    = 11,
    parameter int unsigned STEP = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W:0] STEP_EXT = (W+1)'(STEP);

    logic [W-1:0] value_q;
    logic [W:0]   next_ext;

    // One extra bit so value+STEP never overflows when limit is near 2^W-1.
    assign next_ext = {1'b0, value_q} + STEP_EXT;
    assign wrap     = (next_ext >= {1'b0, limit});
    assign value    = value_q;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            value_q <= '0;
        end else if (enable) begin
            value_q <= wrap ? '0 : next_ext[W-1:0];
        end
    end

endmodule

// File: rtl/radar_frame_sched.sv
// Radar frame scheduler: walks a frame as channel (outer), row pair (middle), column (inner),
// emitting one two-pixel address beat per handshake.
//   clock, reset                   : rising-edge clock, synchronous active-high reset
//   cfg_rows, cfg_cols, cfg_chans  : frame geometry, captured on an accepted start
//   start, abort                   : frame request / terminate current frame
//   out_ready                      : downstream accepts the current beat
//   row_idx1, col_idx1             : first pixel address (row r, column c)
//   row_idx2, col_idx2             : second pixel address (row r+1, or r on an odd-row tail)
//   channel_num                    : channel of the current beat
//   data_vaild, data_start, data_end, pair_vld2 : beat valid and beat qualifiers
//   busy, done, cfg_err            : frame running, completion pulse, rejected-config pulse
module radar_frame_sched
    import radar_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned CH_W  = CH_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] cfg_rows,
    input  logic [IDX_W-1:0] cfg_cols,
    input  logic [CH_W-1:0]  cfg_chans,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ready,
    output logic [IDX_W-1:0] row_idx1,
    output logic [IDX_W-1:0] col_idx1,
    output logic [IDX_W-1:0] row_idx2,
    output logic [IDX_W-1:0] col_idx2,
    output logic [CH_W-1:0]  channel_num,
    output logic             data_vaild,
    output logic             data_start,
    output logic             data_end,
    output logic             pair_vld2,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    sched_state_e state_q, state_d;

    logic [IDX_W-1:0] rows_q, cols_q;
    logic [CH_W-1:0]  chans_q;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_ok, load, handshake, last_beat, live, second_real;
    logic [IDX_W-1:0] col_val, row_val;
    logic [CH_W-1:0]  ch_val;
    logic             col_wrap, row_wrap, ch_wrap;
    logic [IDX_W:0]   row_next_ext;

    assign cfg_ok    = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_chans != '0);
    assign handshake = (state_q == StRun) && out_ready;
    assign last_beat = col_wrap && row_wrap && ch_wrap;

    radar_idx_counter #(
        .W    (IDX_W),
        .STEP (1)
    ) u_col_cnt (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .enable (handshake),
        .limit  (cols_q),
        .value  (col_val),
        .wrap   (col_wrap)
    );

    radar_idx_counter #(
        .W    (IDX_W),
        .STEP (2)
    ) u_row_cnt (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .enable (handshake && col_wrap),
        .limit  (rows_q),
        .value  (row_val),
        .wrap   (row_wrap)
    );

    radar_idx_counter #(
        .W    (CH_W),
        .STEP (1)
    ) u_ch_cnt (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .enable (handshake && col_wrap && row_wrap),
        .limit  (chans_q),
        .value  (ch_val),
        .wrap   (ch_wrap)
    );

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d = StRun;
                        load    = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                // Abort wins over a same-cycle final handshake: no done.
                if (abort) begin
                    state_d = StIdle;
                end else if (handshake && last_beat) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            rows_q    <= '0;
            cols_q    <= '0;
            chans_q   <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            if (load) begin
                rows_q  <= cfg_rows;
                cols_q  <= cfg_cols;
                chans_q <= cfg_chans;
            end
        end
    end

    // Outputs are forced low while reset is held, not just after the first reset edge.
    assign live         = (state_q == StRun) && !reset;
    assign row_next_ext = {1'b0, row_val} + (IDX_W+1)'(1);
    assign second_real  = (row_next_ext < {1'b0, rows_q});

    assign data_vaild  = live;
    assign busy        = live;
    assign row_idx1    = live ? row_val : '0;
    assign col_idx1    = live ? col_val : '0;
    assign col_idx2    = live ? col_val : '0;
    assign row_idx2    = live ? (second_real ? row_next_ext[IDX_W-1:0] : row_val) : '0;
    assign pair_vld2   = live && second_real;
    assign channel_num = live ? ch_val : '0;
    assign data_start  = live && (col_val == '0) && (row_val == '0) && (ch_val == '0);
    assign data_end    = live && last_beat;
    assign done        = done_q && !reset;
    assign cfg_err     = cfg_err_q && !reset;

endmodule

// File: doc/radar_frame_sched.md
RADAR_FRAME_SCHED -- requirements
Module: radar_frame_sched

Interface
REQ-001 SHALL have parameter IDX_W, default 11, row/column index width.
REQ-002 SHALL have parameter CH_W, default 4, channel number width.
REQ-003 SHALL use a single clock and a synchronous active-high reset; no other clocks or asynchronous inputs.
REQ-004 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cfg_rows, input, IDX_W, frame row count, sampled on accepted start.
REQ-007 SHALL have port cfg_cols, input, IDX_W, frame column count, sampled on accepted start.
REQ-008 SHALL have port cfg_chans, input, CH_W, channel count, sampled on accepted start.
REQ-009 SHALL have port start, input, 1, single-cycle frame request.
REQ-010 SHALL have port abort, input, 1, terminate current frame.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts current beat.
REQ-012 SHALL have ports row_idx1, col_idx1, row_idx2, col_idx2, output, IDX_W each, addresses of the two pixels in the beat.
REQ-013 SHALL have port channel_num, output, CH_W, channel of current beat.
REQ-014 SHALL have port data_vaild, output, 1, beat valid.
REQ-015 SHALL have port data_start, output, 1, first beat of frame; qualified by data_vaild.
REQ-016 SHALL have port data_end, output, 1, last beat of frame; qualified by data_vaild.
REQ-017 SHALL have port pair_vld2, output, 1, second pixel address is real (0 on odd-row tail).
REQ-018 SHALL have ports busy, done, cfg_err, output, 1 each: frame in progress; one-cycle completion pulse; one-cycle rejected-config pulse.

Function
REQ-019 SHALL implement states IDLE and RUN; IDLE->RUN on start with all cfg_* nonzero; RUN->IDLE on final handshake or abort.
REQ-020 SHALL, on start in IDLE with any cfg_* equal to zero, stay IDLE and pulse cfg_err the next cycle.
REQ-021 SHALL ignore start while in RUN; cfg_* changes during RUN SHALL have no effect.
REQ-022 SHALL assert data_vaild with the first beat the cycle after the accepted start (latency 1).
REQ-023 SHALL scan order: channel outer (0..cfg_chans-1), row pair middle (r=0,2,4,...), column inner (0..cfg_cols-1).
REQ-024 SHALL drive row_idx1=r, row_idx2=r+1, col_idx1=col_idx2=c, pair_vld2=1; if r+1=cfg_rows then row_idx2=r and pair_vld2=0.
REQ-025 SHALL advance only on handshake (data_vaild and out_ready); while data_vaild=1 and out_ready=0 all outputs SHALL hold stable.
REQ-026 SHALL wrap column to 0 and advance row pair, wrap row pair to 0 and advance channel; beat total = cfg_chans*ceil(cfg_rows/2)*cfg_cols.
REQ-027 SHALL sustain one beat per cycle while out_ready=1 (no bubbles, including across row and channel wraps).
REQ-028 SHALL assert data_start only on beat (ch0,r0,c0) and data_end only on the final beat; a one-beat frame SHALL assert both.
REQ-029 SHALL pulse done the cycle after the final handshake; busy SHALL be 1 exactly in RUN.
REQ-030 SHALL, on abort in RUN, return to IDLE next cycle with data_vaild=0, no data_end and no done; abort SHALL win over a same-cycle final handshake; abort in IDLE SHALL be ignored.
REQ-031 SHALL accept start in the cycle done is high (back-to-back frames).
REQ-032 SHALL handle cfg_rows up to 2^IDX_W-1 without index overflow (pair counter compares against cfg_rows, not r+2).

Reset
REQ-033 SHALL, while reset=1, force state IDLE and all outputs to 0, including all indices and channel_num.
REQ-034 SHALL, on reset mid-frame, discard the frame with no done or data_end; reset SHALL override start and abort.

Structure
REQ-035 SHALL place state enum, IDX_W/CH_W defaults and the beat-count width in shared package radar_pkg.
REQ-036 SHALL instantiate sub-module radar_idx_counter (load, enable, limit, wrap flag) three times: column, row pair, channel.

Verification
REQ-037 SHALL cover rows=4, cols=3, chans=2, out_ready=1 -> 12 consecutive beats, data_start on beat 1, data_end on beat 12, done next cycle.
REQ-038 SHALL cover rows=3, cols=2, chans=1 -> 4 beats; beats 3-4 row_idx1=row_idx2=2, pair_vld2=0.
REQ-039 SHALL cover random out_ready low cycles on rows=4, cols=4, chans=1 -> outputs stable while stalled, exactly 8 beats, ordering unchanged.
REQ-040 SHALL cover abort at beat 5 of 12 -> data_vaild low next cycle, busy=0, no done, no data_end.
REQ-041 SHALL cover start with cfg_cols=0 -> cfg_err pulse, busy stays 0; then rows=1, cols=1, chans=1 -> single beat with data_start=data_end=1.
REQ-042 SHALL cover reset asserted mid-frame and a start during RUN -> outputs 0 after reset; the ignored start does not restart the scan.
